// File: rtl/sram_pixel_fetch_if.sv
// rtl/sram_pixel_fetch_if.sv - SRAM read bus between the pixel fetch stage and the SRAM/arbiter
interface sram_pixel_fetch_if;
    logic [17:0] sram_addr;
    logic [15:0] sram_data;
    logic        sram_oe_n;
    logic        sram_req;

    modport master (
        output sram_addr,
        output sram_oe_n,
        output sram_req,
        input  sram_data
    );

    modport slave (
        input  sram_addr,
        input  sram_oe_n,
        input  sram_req,
        output sram_data
    );
endinterface

// File: rtl/sram_pixel_fetch.sv
// rtl/sram_pixel_fetch.sv - two-tick scan-out stage: SRAM word fetch, byte select, colour decode, sync delay
module sram_pixel_fetch #(
    parameter bit MONO_DEFAULT = 1'b0,
    parameter bit HSYNC_POL    = 1'b0
) (
    input  logic                    clk50M,
    input  logic                    n_reset,
    input  logic                    pix_ce,
    input  logic                    enable,
    input  logic                    mono_sel,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    display_on_in,
    input  logic [18:0]             display_addr,
    sram_pixel_fetch_if.master      bus,
    output logic [1:0]              red,
    output logic [1:0]              green,
    output logic [1:0]              blue,
    output logic                    hsync_out,
    output logic                    vsync_out,
    output logic                    display_on_out,
    output logic                    frame_start
);

    // stage 1: captured timing plus the SRAM address it drives
    logic        s1_addr0_q, s1_addr0_d;
    logic        s1_hs_q,    s1_hs_d;
    logic        s1_vs_q,    s1_vs_d;
    logic        s1_de_q,    s1_de_d;
    logic        s1_first_q, s1_first_d;
    logic [17:0] addr_q,     addr_d;
    logic        oe_n_q,     oe_n_d;
    logic        req_q,      req_d;

    logic        mono_q,     mono_d;
    logic        armed_q,    armed_d;

    // stage 2: pixel and aligned sync outputs
    logic [1:0]  red_q,   red_d;
    logic [1:0]  green_q, green_d;
    logic [1:0]  blue_q,  blue_d;
    logic        hs_out_q, hs_out_d;
    logic        vs_out_q, vs_out_d;
    logic        de_out_q, de_out_d;
    logic        fs_q,     fs_d;

    logic [7:0]  byte_sel;
    logic        vs_rise;
    logic        unused_bits;

    assign byte_sel    = s1_addr0_q ? bus.sram_data[15:8] : bus.sram_data[7:0];
    assign vs_rise     = vsync_in & ~s1_vs_q;
    assign unused_bits = ^{byte_sel[5], byte_sel[2]};

    always_comb begin
        s1_addr0_d = s1_addr0_q;
        s1_hs_d    = s1_hs_q;
        s1_vs_d    = s1_vs_q;
        s1_de_d    = s1_de_q;
        s1_first_d = s1_first_q;
        addr_d     = addr_q;
        oe_n_d     = oe_n_q;
        req_d      = req_q;
        mono_d     = mono_q;
        armed_d    = armed_q;
        red_d      = red_q;
        green_d    = green_q;
        blue_d     = blue_q;
        hs_out_d   = hs_out_q;
        vs_out_d   = vs_out_q;
        de_out_d   = de_out_q;
        fs_d       = 1'b0;

        if (!enable) begin
            // bus released and pipeline flushed without waiting for a pixel strobe
            s1_addr0_d = 1'b0;
            s1_hs_d    = HSYNC_POL;
            s1_vs_d    = 1'b0;
            s1_de_d    = 1'b0;
            s1_first_d = 1'b0;
            addr_d     = 18'd0;
            oe_n_d     = 1'b1;
            req_d      = 1'b0;
            red_d      = 2'b00;
            green_d    = 2'b00;
            blue_d     = 2'b00;
            hs_out_d   = HSYNC_POL;
            vs_out_d   = 1'b0;
            de_out_d   = 1'b0;
        end else if (pix_ce) begin
            if (!s1_de_q) begin
                red_d   = 2'b00;
                green_d = 2'b00;
                blue_d  = 2'b00;
            end else if (mono_q) begin
                red_d   = byte_sel[7:6];
                green_d = byte_sel[7:6];
                blue_d  = byte_sel[7:6];
            end else begin
                red_d   = byte_sel[7:6];
                green_d = byte_sel[4:3];
                blue_d  = byte_sel[1:0];
            end
            hs_out_d = s1_hs_q;
            vs_out_d = s1_vs_q;
            de_out_d = s1_de_q;
            fs_d     = s1_first_q;

            if (vs_rise) begin
                mono_d  = mono_sel;
                armed_d = 1'b1;
            end
            // first visible pixel after a vsync rise carries the frame marker
            s1_first_d = armed_d & display_on_in;
            if (s1_first_d) begin
                armed_d = 1'b0;
            end

            s1_addr0_d = display_addr[0];
            s1_hs_d    = hsync_in;
            s1_vs_d    = vsync_in;
            s1_de_d    = display_on_in;
            addr_d     = display_addr[18:1];
            oe_n_d     = 1'b0;
            req_d      = 1'b1;
        end
    end

    always_ff @(posedge clk50M) begin
        if (!n_reset) begin
            s1_addr0_q <= 1'b0;
            s1_hs_q    <= HSYNC_POL;
            s1_vs_q    <= 1'b0;
            s1_de_q    <= 1'b0;
            s1_first_q <= 1'b0;
            addr_q     <= 18'd0;
            oe_n_q     <= 1'b1;
            req_q      <= 1'b0;
            mono_q     <= MONO_DEFAULT;
            armed_q    <= 1'b0;
            red_q      <= 2'b00;
            green_q    <= 2'b00;
            blue_q     <= 2'b00;
            hs_out_q   <= HSYNC_POL;
            vs_out_q   <= 1'b0;
            de_out_q   <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            s1_addr0_q <= s1_addr0_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_de_q    <= s1_de_d;
            s1_first_q <= s1_first_d;
            addr_q     <= addr_d;
            oe_n_q     <= oe_n_d;
            req_q      <= req_d;
            mono_q     <= mono_d;
            armed_q    <= armed_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
            hs_out_q   <= hs_out_d;
            vs_out_q   <= vs_out_d;
            de_out_q   <= de_out_d;
            fs_q       <= fs_d;
        end
    end

    assign bus.sram_addr  = addr_q;
    assign bus.sram_oe_n  = oe_n_q;
    assign bus.sram_req   = req_q;
    assign red            = red_q;
    assign green          = green_q;
    assign blue           = blue_q;
    assign hsync_out      = hs_out_q;
    assign vsync_out      = vs_out_q;
    assign display_on_out = de_out_q;
    assign frame_start    = fs_q;

endmodule

// File: tb/tb_sram_pixel_fetch.sv
// tb/tb_sram_pixel_fetch.sv - directed bench with a per-pixel reference model for sram_pixel_fetch
module tb_sram_pixel_fetch;
    localparam bit HPOL = 1'b1;

    logic        clk50M = 1'b0;
    logic        n_reset = 1'b0;
    logic        pix_ce = 1'b0;
    logic        enable = 1'b0;
    logic        mono_sel = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b0;
    logic        display_on_in = 1'b0;
    logic [18:0] display_addr = 19'd0;
    logic [1:0]  red, green, blue;
    logic        hsync_out, vsync_out, display_on_out, frame_start;

    sram_pixel_fetch_if bus_if ();

    sram_pixel_fetch #(.MONO_DEFAULT(1'b0), .HSYNC_POL(HPOL)) dut (
        .clk50M         (clk50M),
        .n_reset        (n_reset),
        .pix_ce         (pix_ce),
        .enable         (enable),
        .mono_sel       (mono_sel),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .display_on_in  (display_on_in),
        .display_addr   (display_addr),
        .bus            (bus_if.master),
        .red            (red),
        .green          (green),
        .blue           (blue),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .display_on_out (display_on_out),
        .frame_start    (frame_start)
    );

    always #10 clk50M = ~clk50M;

    int checks = 0;
    int failures = 0;
    int fs_count = 0;
    logic snap_fs = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [5:0] decode(input logic [7:0] b, input logic mono);
        return mono ? {b[7:6], b[7:6], b[7:6]} : {b[7:6], b[4:3], b[1:0]};
    endfunction

    // reference: the pixel waiting between ticks, and the outputs it must produce
    logic        p_valid = 1'b0, p_addr0 = 1'b0, p_hs = 1'b0, p_vs = 1'b0, p_de = 1'b0;
    logic        p_mono = 1'b0, p_first = 1'b0;
    logic        m_mode = 1'b0, m_armed = 1'b0;
    logic [17:0] e_addr = 18'd0;
    logic        e_oe = 1'b1, e_req = 1'b0;
    logic [5:0]  e_rgb = 6'd0;
    logic        e_hs = HPOL, e_vs = 1'b0, e_de = 1'b0, e_fs = 1'b0;

    always @(posedge clk50M) begin : model
        logic [7:0] bt;
        logic       rise, mode_n, armed_n, first_n;
        bt = p_addr0 ? bus_if.sram_data[15:8] : bus_if.sram_data[7:0];
        if (!n_reset || !enable) begin
            p_valid <= 1'b0; p_first <= 1'b0; p_vs <= 1'b0;
            if (!n_reset) begin
                m_mode <= 1'b0; m_armed <= 1'b0;
            end
            e_addr <= 18'd0; e_oe <= 1'b1; e_req <= 1'b0; e_rgb <= 6'd0;
            e_hs <= HPOL; e_vs <= 1'b0; e_de <= 1'b0; e_fs <= 1'b0;
        end else if (pix_ce) begin
            e_rgb <= (p_valid && p_de) ? decode(bt, p_mono) : 6'd0;
            e_hs  <= p_valid ? p_hs : HPOL;
            e_vs  <= p_valid && p_vs;
            e_de  <= p_valid && p_de;
            e_fs  <= p_valid && p_first;
            rise    = vsync_in && !(p_valid && p_vs);
            mode_n  = rise ? mono_sel : m_mode;
            armed_n = m_armed || rise;
            first_n = armed_n && display_on_in;
            m_mode  <= mode_n;
            m_armed <= armed_n && !first_n;
            p_valid <= 1'b1; p_addr0 <= display_addr[0]; p_hs <= hsync_in;
            p_vs <= vsync_in; p_de <= display_on_in; p_mono <= mode_n; p_first <= first_n;
            e_addr <= display_addr[18:1]; e_oe <= 1'b0; e_req <= 1'b1;
        end else begin
            e_fs <= 1'b0;
        end
    end

    always @(negedge clk50M) begin
        chk("bus", {12'd0, bus_if.sram_addr, bus_if.sram_oe_n, bus_if.sram_req}, {12'd0, e_addr, e_oe, e_req});
        chk("pixel", {26'd0, red, green, blue}, {26'd0, e_rgb});
        chk("sync", {29'd0, hsync_out, vsync_out, display_on_out}, {29'd0, e_hs, e_vs, e_de});
        chk("frame_start", {31'd0, frame_start}, {31'd0, e_fs});
        if (frame_start === 1'b1) fs_count++;
    end

    task automatic tick();
        pix_ce = 1'b1;
        @(posedge clk50M); #1;
        snap_fs = frame_start;
        pix_ce = 1'b0;
        @(posedge clk50M); #1;
    endtask

    int low_count, first_low, fs_base;

    initial begin
        bus_if.sram_data = 16'h0000;
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pix_ce = ~pix_ce;
            @(posedge clk50M); #1;
        end
        pix_ce = 1'b0;
        chk("rst_oe_n", {31'd0, bus_if.sram_oe_n}, 32'd1);
        chk("rst_req", {31'd0, bus_if.sram_req}, 32'd0);
        chk("rst_addr", {14'd0, bus_if.sram_addr}, 32'd0);
        chk("rst_rgb", {26'd0, red, green, blue}, 32'd0);
        chk("rst_sync", {29'd0, hsync_out, vsync_out, display_on_out}, {29'd0, HPOL, 2'b00});
        chk("rst_fs_count", fs_count, 0);

        n_reset = 1'b1;
        display_on_in = 1'b1; display_addr = 19'h00003; bus_if.sram_data = 16'hE01C;
        tick();
        chk("bsel_addr", {14'd0, bus_if.sram_addr}, 32'h1);
        chk("bsel_oe_req", {30'd0, bus_if.sram_oe_n, bus_if.sram_req}, 32'b01);
        tick();
        chk("bsel_upper", {26'd0, red, green, blue}, 32'b11_00_00);
        display_addr = 19'h00002;
        tick();
        tick();
        chk("bsel_lower", {26'd0, red, green, blue}, 32'b00_11_00);

        display_on_in = 1'b0; display_addr = 19'd0;
        tick(); tick();
        low_count = 0; first_low = -1;
        for (int i = 0; i < 100; i++) begin
            hsync_in = (i < 96) ? 1'b0 : 1'b1;
            tick();
            if (hsync_out == 1'b0) begin
                low_count++;
                if (first_low < 0) first_low = i;
            end
        end
        chk("hs_low_len", low_count, 96);
        chk("hs_delay", first_low, 1);

        display_on_in = 1'b1; bus_if.sram_data = 16'h0080; mono_sel = 1'b1;
        repeat (3) tick();
        chk("mode_midframe", {26'd0, red, green, blue}, 32'b10_00_00);
        fs_base = fs_count;
        display_on_in = 1'b0; vsync_in = 1'b1;
        repeat (3) tick();
        vsync_in = 1'b0;
        repeat (2) tick();
        display_on_in = 1'b1;
        tick();
        chk("fs_not_early", {31'd0, snap_fs}, 32'd0);
        tick();
        chk("fs_pulse", {31'd0, snap_fs}, 32'd1);
        chk("mode_mono", {26'd0, red, green, blue}, 32'b10_10_10);
        mono_sel = 1'b0;
        repeat (3) tick();
        chk("mode_hold", {26'd0, red, green, blue}, 32'b10_10_10);
        chk("fs_once", fs_count, fs_base + 1);

        enable = 1'b0;
        @(posedge clk50M); #1;
        chk("rel_bus", {12'd0, bus_if.sram_addr, bus_if.sram_oe_n, bus_if.sram_req}, 32'b10);
        chk("rel_rgb", {26'd0, red, green, blue}, 32'd0);
        chk("rel_de", {31'd0, display_on_out}, 32'd0);
        @(posedge clk50M); #1;
        bus_if.sram_data = 16'h00FF;
        enable = 1'b1;
        tick();
        chk("reen_blank", {26'd0, red, green, blue}, 32'd0);
        tick();
        chk("reen_valid", {26'd0, red, green, blue}, 32'b11_11_11);

        display_addr = 19'h7FFFF; bus_if.sram_data = 16'hFF00;
        tick();
        chk("wrap_addr", {14'd0, bus_if.sram_addr}, 32'h3FFFF);
        tick();
        chk("wrap_rgb", {26'd0, red, green, blue}, 32'b11_11_11);

        pix_ce = 1'b1;
        for (int i = 0; i < 8; i++) begin
            display_addr = 19'(i * 3);
            bus_if.sram_data = 16'(16'h1357 * (i + 1));
            @(posedge clk50M); #1;
        end
        pix_ce = 1'b0;
        n_reset = 1'b0;
        @(posedge clk50M); #1;
        n_reset = 1'b1;
        chk("midreset_rgb", {26'd0, red, green, blue}, 32'd0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
